fifo_bridge_master: RTL and testbench
=====================================

FIFO_BRIDGE_MASTER -- requirements
Module: fifo_bridge_master

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000, FIFO window base; status at +0x0, pop at +0x4, push/out-status at +0x8.
REQ-002 SHALL have parameter TIMEOUT, default 16, the maximum number of cycles to wait for mem_ready.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset; one clock; reset is synchronous and active-low.
REQ-005 start  input  1  one-cycle pulse that starts a transfer.
REQ-006 word_count  input  16  number of words to move; sampled on start.
REQ-007 abort  input  1  stop the transfer at the next transaction boundary.
REQ-008 mem_valid  output  1  bus request, initiator side.
REQ-009 mem_addr  output  32  bus address.
REQ-010 mem_wstrb  output  4  byte write strobes; 0 means read.
REQ-011 mem_wdata  output  32  write data.
REQ-012 mem_rdata  input  32  read data, valid when mem_ready=1.
REQ-013 mem_ready  input  1  registered responder acknowledge.
REQ-014 busy  output  1  high from the start acceptance until the terminal state.
REQ-015 done  output  1  one-cycle pulse on normal completion or abort.
REQ-016 error  output  1  sticky timeout flag; cleared by the next accepted start or by reset.
REQ-017 words_done  output  16  count of words pushed to FIFO_OUT in the current or last transfer.
REQ-018 last_word  output  32  last word pushed.

Function
REQ-019 Each bus transaction SHALL assert mem_valid for exactly one cycle, with mem_addr, mem_wstrb and mem_wdata valid that cycle; mem_valid SHALL stay low in the following wait cycles, so the registered responder never performs a double access.
REQ-020 In the wait state, the first cycle with mem_ready=1 SHALL complete the transaction and mem_rdata SHALL be captured that cycle; mem_ready seen outside a wait state SHALL be ignored.
REQ-021 A wait exceeding TIMEOUT cycles without mem_ready SHALL set error, pulse done, clear busy and go to IDLE.
REQ-022 FSM states SHALL be IDLE, POLL_REQ, POLL_WAIT, POP_REQ, POP_WAIT, CHK_REQ, CHK_WAIT, PUSH_REQ, PUSH_WAIT, FINISH.
REQ-023 IDLE: start=1 -> latch word_count, clear words_done and error, set busy; go to FINISH if word_count=0, else go to POLL_REQ.
REQ-024 POLL: read BASE_ADDR with wstrb=0; rdata[1] (empty)=1 -> POLL_REQ again; otherwise -> POP_REQ.
REQ-025 POP: read BASE_ADDR+4 with wstrb=0; captured rdata is held as the data word; then -> CHK_REQ.
REQ-026 CHK: read BASE_ADDR+8 with wstrb=0; rdata[0] (full)=1 -> CHK_REQ again, still holding the data word; otherwise -> PUSH_REQ.
REQ-027 PUSH: write BASE_ADDR+8 with wstrb=4'hF and wdata equal to the data word; on ready, increment words_done, update last_word, then:
- words_done (new value) equals the latched count -> FINISH;
- otherwise -> POLL_REQ.
REQ-028 FINISH: pulse done for one cycle, clear busy, go to IDLE.
REQ-029 words_done SHALL be 16-bit unsigned; latched count 16'hFFFF SHALL complete without wrap.
REQ-030 start while busy SHALL be ignored.
REQ-031 abort SHALL be honoured only in a *_REQ state or after a wait completes, never mid-wait.
REQ-032 A popped word SHALL always be pushed before abort takes effect, so no data is lost; the block then goes to FINISH.
REQ-033 abort and start in the same IDLE cycle: start SHALL win.
REQ-034 Minimum throughput SHALL be 8 cycles per word when the responder answers in 1 cycle.

Reset
REQ-035 When rst=0 at a clock edge, the block SHALL go to IDLE.
REQ-036 On that reset, mem_valid, busy, done and error SHALL be 0.
REQ-037 On that reset, mem_addr, mem_wdata, words_done and last_word SHALL be 0, and mem_wstrb SHALL be 4'h0.
REQ-038 Reset mid-transaction SHALL drop any pending wait without a retry.

Verification
REQ-039 Normal transfer: word_count=3, FIFO_IN holds A,B,C, FIFO_OUT empty -> pushes A,B,C in order; words_done=3; last_word=C; one done pulse; error=0.
REQ-040 Empty poll: FIFO_IN empty for 5 polls, then holds 0x1234 -> status reads repeat, exactly one pop; push 0x1234.
REQ-041 Full back-pressure: fifo2_full=1 for 4 checks -> exactly one pop and no push until full=0; the pushed data equals the popped word.
REQ-042 Timeout: responder withholds mem_ready -> error=1 after TIMEOUT+1 wait cycles; done pulses; busy=0; next start clears error.
REQ-043 Abort during POP_WAIT with word_count=10 -> that word is pushed; done pulses; words_done=current+1.
REQ-044 Handshake check: every mem_valid pulse is 1 cycle wide; zero word_count gives done 2 cycles after start with no bus activity; rst=0 mid-PUSH_WAIT returns all outputs to their reset values.

Source files
------------

// File: rtl/fifo_bridge_master.sv
// fifo_bridge_master: bus initiator that drains a memory-mapped input FIFO
// into a memory-mapped output FIFO. Each word is moved with four single-beat
// transactions: poll status, pop, check output status, push.
module fifo_bridge_master #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [15:0] word_count_i,
    input  logic        abort_i,
    output logic        mem_valid_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_wstrb_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ready_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic [15:0] words_done_o,
    output logic [31:0] last_word_o
);

    typedef enum logic [3:0] {
        IDLE,
        POLL_REQ,
        POLL_WAIT,
        POP_REQ,
        POP_WAIT,
        CHK_REQ,
        CHK_WAIT,
        PUSH_REQ,
        PUSH_WAIT,
        FINISH
    } state_e;

    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);
    localparam logic [31:0] POP_ADDR    = BASE_ADDR + 32'h4;
    localparam logic [31:0] OUT_ADDR    = BASE_ADDR + 32'h8;

    state_e      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [15:0] words_done_q, words_done_d;
    logic [31:0] last_word_q, last_word_d;
    logic [31:0] data_q, data_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic        abort_q, abort_d;

    logic        in_wait;
    logic        wait_timeout;
    logic        abort_pend;
    logic        last_push;

    assign in_wait      = (state_q == POLL_WAIT) || (state_q == POP_WAIT) ||
                          (state_q == CHK_WAIT)  || (state_q == PUSH_WAIT);
    // A wait expires on the first cycle beyond TIMEOUT that still has no ready.
    assign wait_timeout = in_wait && !mem_ready_i && (wait_cnt_q == TIMEOUT_CNT);
    // An abort pulse is remembered until the next transaction boundary.
    assign abort_pend   = abort_q || abort_i;
    assign last_push    = ((words_done_q + 16'd1) == count_q);

    // State register.
    always_ff @(posedge clk_i) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block evaluation order.
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection; abort is only looked at when a wait has completed.
    always_comb begin
        // NOTE: every always_comb target gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = (word_count_i == 16'd0) ? FINISH : POLL_REQ;
                end
            end
            POLL_REQ: state_d = POLL_WAIT;
            POLL_WAIT: begin
                if (mem_ready_i) begin
                    if (abort_pend)          state_d = FINISH;
                    else if (mem_rdata_i[1]) state_d = POLL_REQ;
                    else                     state_d = POP_REQ;
                end else if (wait_timeout) begin
                    state_d = IDLE;
                end
            end
            POP_REQ: state_d = POP_WAIT;
            POP_WAIT: begin
                // A popped word is always carried through to the push.
                if (mem_ready_i)       state_d = CHK_REQ;
                else if (wait_timeout) state_d = IDLE;
            end
            CHK_REQ: state_d = CHK_WAIT;
            CHK_WAIT: begin
                if (mem_ready_i)       state_d = mem_rdata_i[0] ? CHK_REQ : PUSH_REQ;
                else if (wait_timeout) state_d = IDLE;
            end
            PUSH_REQ: state_d = PUSH_WAIT;
            PUSH_WAIT: begin
                if (mem_ready_i)       state_d = (last_push || abort_pend) ? FINISH : POLL_REQ;
                else if (wait_timeout) state_d = IDLE;
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus request outputs: one-cycle request decoded from the *_REQ states.
    always_comb begin
        mem_valid_o = 1'b0;
        mem_addr_o  = 32'h0;
        mem_wstrb_o = 4'h0;
        mem_wdata_o = 32'h0;
        case (state_q)
            POLL_REQ: begin
                mem_valid_o = 1'b1;
                mem_addr_o  = BASE_ADDR;
            end
            POP_REQ: begin
                mem_valid_o = 1'b1;
                mem_addr_o  = POP_ADDR;
            end
            CHK_REQ: begin
                mem_valid_o = 1'b1;
                mem_addr_o  = OUT_ADDR;
            end
            PUSH_REQ: begin
                mem_valid_o = 1'b1;
                mem_addr_o  = OUT_ADDR;
                mem_wstrb_o = 4'hF;
                mem_wdata_o = data_q;
            end
            default: ;
        endcase
    end

    // Datapath next values: counters, captured data, status flags.
    always_comb begin
        count_d      = count_q;
        words_done_d = words_done_q;
        last_word_d  = last_word_q;
        data_d       = data_q;
        wait_cnt_d   = wait_cnt_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        error_d      = error_q;
        abort_d      = abort_q;

        if (state_q == IDLE) begin
            // start wins over a coincident abort: the pending flag is cleared.
            if (start_i) begin
                count_d      = word_count_i;
                words_done_d = 16'd0;
                error_d      = 1'b0;
                busy_d       = 1'b1;
                abort_d      = 1'b0;
            end
        end else if (abort_i) begin
            abort_d = 1'b1;
        end

        if (in_wait) begin
            wait_cnt_d = wait_cnt_q + 16'd1;
        end else begin
            wait_cnt_d = 16'd0;
        end

        if (state_q == POP_WAIT && mem_ready_i) begin
            data_d = mem_rdata_i;
        end

        if (state_q == PUSH_WAIT && mem_ready_i) begin
            words_done_d = words_done_q + 16'd1;
            last_word_d  = data_q;
        end

        if (wait_timeout) begin
            error_d = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
        end

        if (state_q == FINISH) begin
            done_d = 1'b1;
            busy_d = 1'b0;
        end
    end

    // Datapath registers; reset drops any outstanding wait outright.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q      <= 16'd0;
            words_done_q <= 16'd0;
            last_word_q  <= 32'h0;
            data_q       <= 32'h0;
            wait_cnt_q   <= 16'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            count_q      <= count_d;
            words_done_q <= words_done_d;
            last_word_q  <= last_word_d;
            data_q       <= data_d;
            wait_cnt_q   <= wait_cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            abort_q      <= abort_d;
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign error_o      = error_q;
    assign words_done_o = words_done_q;
    assign last_word_o  = last_word_q;

endmodule

// File: tb/tb_fifo_bridge_master.sv
// tb_fifo_bridge_master: directed bench with a registered FIFO-window responder.
module tb_fifo_bridge_master;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] word_count;
    logic        abort;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ready = 1'b0;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_done;
    logic [31:0] last_word;

    int checks = 0;
    int errors = 0;

    // Responder configuration (written only by the stimulus block).
    int          empty_until = 0;
    int          full_until  = 0;
    int          extra_delay = 0;
    bit          withhold    = 1'b0;
    logic [31:0] fifo_data [16];

    // Responder bookkeeping (written only by the responder).
    int          n_status = 0, n_pop = 0, n_chk = 0, n_push = 0;
    int          n_valid = 0, n_done = 0;
    int          valid_wide = 0, done_wide = 0, bad_access = 0, push_while_full = 0;
    logic [31:0] pushed [$];

    fifo_bridge_master dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .word_count_i (word_count),
        .abort_i      (abort),
        .mem_valid_o  (mem_valid),
        .mem_addr_o   (mem_addr),
        .mem_wstrb_o  (mem_wstrb),
        .mem_wdata_o  (mem_wdata),
        .mem_rdata_i  (mem_rdata),
        .mem_ready_i  (mem_ready),
        .busy_o       (busy),
        .done_o       (done),
        .error_o      (error),
        .words_done_o (words_done),
        .last_word_o  (last_word)
    );

    always #5 clk = ~clk;

    // Registered responder: acknowledges 1 + extra_delay cycles after a request.
    bit          pend = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_data = 32'h0;
    bit          prev_valid = 1'b0, prev_done = 1'b0, last_chk_full = 1'b0;
    logic [31:0] resp;
    always @(posedge clk) begin
        if (!rst_n) begin
            mem_ready  <= 1'b0;
            pend       = 1'b0;
            prev_valid = 1'b0;
            prev_done  = 1'b0;
        end else begin
            mem_ready <= 1'b0;
            if (mem_valid && prev_valid) valid_wide++;
            if (done && prev_done) done_wide++;
            if (done) n_done++;
            prev_valid = mem_valid;
            prev_done  = done;
            if (pend) begin
                if (pend_cnt == 0) begin
                    mem_ready <= 1'b1;
                    mem_rdata <= pend_data;
                    pend = 1'b0;
                end else begin
                    pend_cnt--;
                end
            end
            if (mem_valid) begin
                n_valid++;
                resp = 32'hDEAD_BEEF;
                if (mem_addr == BASE && mem_wstrb == 4'h0) begin
                    resp = 32'hA5A5_A5A4 | ((n_status < empty_until) ? 32'h2 : 32'h0);
                    n_status++;
                end else if (mem_addr == BASE + 32'h4 && mem_wstrb == 4'h0) begin
                    resp = fifo_data[n_pop % 16];
                    n_pop++;
                end else if (mem_addr == BASE + 32'h8 && mem_wstrb == 4'h0) begin
                    last_chk_full = (n_chk < full_until);
                    resp = 32'h5A5A_5A5C | (last_chk_full ? 32'h1 : 32'h0);
                    n_chk++;
                end else if (mem_addr == BASE + 32'h8 && mem_wstrb == 4'hF) begin
                    if (last_chk_full) push_while_full++;
                    pushed.push_back(mem_wdata);
                    n_push++;
                end else begin
                    bad_access++;
                end
                if (!withhold) begin
                    if (extra_delay == 0) begin
                        mem_ready <= 1'b1;
                        mem_rdata <= resp;
                    end else begin
                        pend      = 1'b1;
                        pend_cnt  = extra_delay - 1;
                        pend_data = resp;
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start(input logic [15:0] cnt, input logic ab);
        start      = 1'b1;
        word_count = cnt;
        abort      = ab;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
    endtask

    // Counts cycles until done; the final done comparison doubles as the bound check.
    task automatic wait_done(input string tag, input int budget, output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        check(tag, {31'h0, done}, 32'h1);
    endtask

    int s_status, s_pop, s_chk, s_push, s_valid, s_done, s_q;
    task automatic snap();
        s_status = n_status;
        s_pop    = n_pop;
        s_chk    = n_chk;
        s_push   = n_push;
        s_valid  = n_valid;
        s_done   = n_done;
        s_q      = pushed.size();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int          cyc;
    int          p0;
    int          guard;
    logic [31:0] w;
    initial begin
        for (int i = 0; i < 16; i++) fifo_data[i] = 32'hD000_0000 + 32'(i);
        rst_n = 1'b0; start = 1'b0; word_count = 16'd0; abort = 1'b0;
        step(3);
        check("rst_valid", {31'h0, mem_valid}, 32'h0);
        check("rst_busy",  {31'h0, busy}, 32'h0);
        check("rst_done",  {31'h0, done}, 32'h0);
        check("rst_error", {31'h0, error}, 32'h0);
        check("rst_addr",  mem_addr, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_wstrb", {28'h0, mem_wstrb}, 32'h0);
        check("rst_wdone", {16'h0, words_done}, 32'h0);
        check("rst_last",  last_word, 32'h0);
        rst_n = 1'b1;
        step(2);

        // Normal transfer of A, B, C at full rate: 3 * 8 cycles + FINISH.
        snap();
        p0 = n_pop;
        fifo_data[p0 % 16]       = 32'hAAAA_0001;
        fifo_data[(p0 + 1) % 16] = 32'hBBBB_0002;
        fifo_data[(p0 + 2) % 16] = 32'hCCCC_0003;
        empty_until = n_status;
        full_until  = n_chk;
        do_start(16'd3, 1'b0);
        check("t1_busy", {31'h0, busy}, 32'h1);
        wait_done("t1_done", 200, cyc);
        check("t1_cycles", 32'(cyc), 32'd25);
        check("t1_busy_end", {31'h0, busy}, 32'h0);
        check("t1_wdone", {16'h0, words_done}, 32'd3);
        check("t1_last", last_word, 32'hCCCC_0003);
        check("t1_error", {31'h0, error}, 32'h0);
        step(3);
        check("t1_pushes", 32'(n_push - s_push), 32'd3);
        check("t1_push0", pushed[s_q],     32'hAAAA_0001);
        check("t1_push1", pushed[s_q + 1], 32'hBBBB_0002);
        check("t1_push2", pushed[s_q + 2], 32'hCCCC_0003);
        check("t1_done_cnt", 32'(n_done - s_done), 32'd1);

        // Input FIFO empty for five polls, then holds 0x1234.
        snap();
        fifo_data[n_pop % 16] = 32'h0000_1234;
        empty_until = n_status + 5;
        do_start(16'd1, 1'b0);
        wait_done("t2_done", 200, cyc);
        check("t2_cycles", 32'(cyc), 32'd19);
        step(2);
        check("t2_polls", 32'(n_status - s_status), 32'd6);
        check("t2_pops", 32'(n_pop - s_pop), 32'd1);
        check("t2_push", pushed[s_q], 32'h0000_1234);
        check("t2_wdone", {16'h0, words_done}, 32'd1);

        // Output FIFO full for four checks.
        snap();
        fifo_data[n_pop % 16] = 32'hCAFE_0003;
        full_until = n_chk + 4;
        do_start(16'd1, 1'b0);
        wait_done("t3_done", 200, cyc);
        check("t3_cycles", 32'(cyc), 32'd17);
        step(2);
        check("t3_chks", 32'(n_chk - s_chk), 32'd5);
        check("t3_pops", 32'(n_pop - s_pop), 32'd1);
        check("t3_pushes", 32'(n_push - s_push), 32'd1);
        check("t3_push", pushed[s_q], 32'hCAFE_0003);
        check("t3_last", last_word, 32'hCAFE_0003);

        // Responder silent: timeout after TIMEOUT+1 wait cycles (E0 start, E1 wait, E18).
        snap();
        withhold = 1'b1;
        do_start(16'd2, 1'b0);
        wait_done("t4_done", 200, cyc);
        check("t4_cycles", 32'(cyc), 32'd18);
        check("t4_error", {31'h0, error}, 32'h1);
        check("t4_busy", {31'h0, busy}, 32'h0);
        step(4);
        check("t4_error_sticky", {31'h0, error}, 32'h1);
        check("t4_valids", 32'(n_valid - s_valid), 32'd1);
        withhold = 1'b0;
        fifo_data[n_pop % 16] = 32'h0BAD_F00D;
        do_start(16'd1, 1'b0);
        check("t4_error_clr", {31'h0, error}, 32'h0);
        wait_done("t4b_done", 200, cyc);
        check("t4b_wdone", {16'h0, words_done}, 32'd1);
        check("t4b_last", last_word, 32'h0BAD_F00D);
        step(2);

        // Abort while the second pop is outstanding, word_count = 10.
        snap();
        p0 = n_pop;
        extra_delay = 2;
        do_start(16'd10, 1'b0);
        guard = 0;
        while (n_pop - s_pop < 2 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("t5_reach_pop", 32'(n_pop - s_pop), 32'd2);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        wait_done("t5_done", 200, cyc);
        check("t5_wdone", {16'h0, words_done}, 32'd2);
        check("t5_last", last_word, fifo_data[(p0 + 1) % 16]);
        check("t5_error", {31'h0, error}, 32'h0);
        step(2);
        check("t5_pushes", 32'(n_push - s_push), 32'd2);
        check("t5_pops", 32'(n_pop - s_pop), 32'd2);
        check("t5_push1", pushed[s_q + 1], fifo_data[(p0 + 1) % 16]);
        extra_delay = 0;

        // Zero word count: done two cycles after start, no bus traffic.
        snap();
        do_start(16'd0, 1'b0);
        wait_done("t6_done", 20, cyc);
        check("t6_cycles", 32'(cyc), 32'd1);
        check("t6_valids", 32'(n_valid - s_valid), 32'd0);
        check("t6_wdone", {16'h0, words_done}, 32'd0);
        step(2);

        // start while busy is ignored.
        snap();
        do_start(16'd2, 1'b0);
        step(5);
        start = 1'b1; word_count = 16'd5;
        step(1);
        start = 1'b0;
        check("t7_busy", {31'h0, busy}, 32'h1);
        wait_done("t7_done", 200, cyc);
        check("t7_wdone", {16'h0, words_done}, 32'd2);
        step(2);
        check("t7_pushes", 32'(n_push - s_push), 32'd2);

        // start and abort together in IDLE: start wins.
        snap();
        do_start(16'd2, 1'b1);
        wait_done("t8_done", 200, cyc);
        check("t8_wdone", {16'h0, words_done}, 32'd2);
        step(2);

        // Reset while a push is outstanding.
        extra_delay = 3;
        snap();
        w = fifo_data[n_pop % 16];
        do_start(16'd2, 1'b0);
        guard = 0;
        while (n_push == s_push && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("t9_push_seen", 32'(n_push - s_push), 32'd1);
        check("t9_wdata_seen", pushed[s_q], w);
        rst_n = 1'b0;
        step(1);
        check("t9_valid", {31'h0, mem_valid}, 32'h0);
        check("t9_busy",  {31'h0, busy}, 32'h0);
        check("t9_done",  {31'h0, done}, 32'h0);
        check("t9_error", {31'h0, error}, 32'h0);
        check("t9_addr",  mem_addr, 32'h0);
        check("t9_wdata", mem_wdata, 32'h0);
        check("t9_wstrb", {28'h0, mem_wstrb}, 32'h0);
        check("t9_wdone", {16'h0, words_done}, 32'h0);
        check("t9_last",  last_word, 32'h0);
        rst_n = 1'b1;
        extra_delay = 0;
        snap();
        step(10);
        check("t9_quiet", 32'(n_valid - s_valid), 32'd0);
        check("t9_idle_busy", {31'h0, busy}, 32'h0);

        // Whole-run handshake properties.
        check("valid_width", 32'(valid_wide), 32'd0);
        check("done_width", 32'(done_wide), 32'd0);
        check("bad_access", 32'(bad_access), 32'd0);
        check("push_while_full", 32'(push_while_full), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
